id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 49 ++++
 rtl/id_ex_stage_fwd_mux.sv | 33 +++
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared parameters for the ID/EX pipeline register slice.
// Holds the datapath width, register-index width, the packed control word
// layout (both as a packed struct and as explicit bit positions) and the
// forwarding match helper used by the stage and its forwarding muxes.
package id_ex_stage_pkg;

    localparam int XLEN   = 64;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 15;

    // Control word bit positions, MSB first
    localparam int CTRL_ALU_OP_LSB   = 11;
    localparam int CTRL_ALU_OP_W     = 4;
    localparam int CTRL_SUB          = 10;
    localparam int CTRL_SLT_SIGNED   = 9;
    localparam int CTRL_SLT_UNSIGNED = 8;
    localparam int CTRL_WORD_OP      = 7;
    localparam int CTRL_USE_PC       = 6;
    localparam int CTRL_USE_IMM      = 5;
    localparam int CTRL_RD_WEN       = 4;
    localparam int CTRL_MEM_READ     = 3;
    localparam int CTRL_MEM_WRITE    = 2;
    localparam int CTRL_RS1_USED     = 1;
    localparam int CTRL_RS2_USED     = 0;

    typedef struct packed {
        logic [CTRL_ALU_OP_W-1:0] alu_op;
        logic                     sub;
        logic                     slt_signed;
        logic                     slt_unsigned;
        logic                     word_op;
        logic                     use_pc;
        logic                     use_imm;
        logic                     rd_wen;
        logic                     mem_read;
        logic                     mem_write;
        logic                     rs1_used;
        logic                     rs2_used;
    } ctrl_t;

    // A pending write matches an operand only for a live write to the same,
    // non-zero register; x0 is hardwired and never forwarded.
    function automatic logic fwd_hit(input logic [REG_W-1:0] idx,
                                     input logic             wen,
                                     input logic [REG_W-1:0] wr_idx);
        return wen && (wr_idx == idx) && (idx != '0);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding selection for the EX stage.
// Ports:
//   idx         - register index of the held operand
//   stored_data - operand value captured in the ID/EX register
//   mem_*       - result of the instruction currently in MEM
//   wb_*        - register-file write currently in progress
//   fwd_data    - freshest value of the operand (MEM over WB over stored)
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = XLEN
) (
    input  logic [REG_W-1:0]  idx,
    input  logic [DATA_W-1:0] stored_data,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic              mem_wen,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              wb_wen,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] fwd_data
);

    always_comb begin
        fwd_data = stored_data;
        if (fwd_hit(idx, mem_wen, mem_rd)) begin
            fwd_data = mem_data;
        end else if (fwd_hit(idx, wb_wen, wb_rd)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and operand forwarding.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   id_valid / id_ready            - decode handshake
//   id_pc, id_ctrl, id_rs1/2, id_rd, id_rs1/2_data, id_imm - decoded instruction
//   flush                          - discard stage contents and the offer
//   mem_rd/mem_wen/mem_data        - MEM-stage result for forwarding
//   wb_rd/wb_wen/wb_data           - register-file write for forwarding/snoop
//   ex_ready                       - downstream consumes the held instruction
//   ex_valid, ex_pc, ex_ctrl, ex_rd - registered instruction fields
//   ex_a, ex_b, ex_store_data      - forwarded operands and store data
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              flush,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic              mem_wen,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              wb_wen,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data
);

    ctrl_t id_ctrl_s;
    assign id_ctrl_s = ctrl_t'(id_ctrl);

    logic              vld_p0;
    logic [DATA_W-1:0] pc_p0;
    ctrl_t             ctrl_p0;
    logic [REG_W-1:0]  rd_p0;
    logic [REG_W-1:0]  rs1_idx_p0;
    logic [REG_W-1:0]  rs2_idx_p0;
    logic [DATA_W-1:0] rs1_data_p0;
    logic [DATA_W-1:0] rs2_data_p0;
    logic [DATA_W-1:0] imm_p0;

    logic advance;
    logic stall;
    logic load_en;

    // Value captured for an operand: a register-file write landing this very
    // cycle would otherwise be missed, since the regfile read predates it.
    function automatic logic [DATA_W-1:0] wb_snoop(input logic [REG_W-1:0]  idx,
                                                   input logic [DATA_W-1:0] dflt);
        return fwd_hit(idx, wb_wen, wb_rd) ? wb_data : dflt;
    endfunction

    // A load in EX has no data until after MEM, so a consumer in ID must wait.
    assign stall = vld_p0 && ctrl_p0.mem_read && (rd_p0 != '0) &&
                   ((id_ctrl_s.rs1_used && (id_rs1 == rd_p0)) ||
                    (id_ctrl_s.rs2_used && (id_rs2 == rd_p0)));

    assign advance = !vld_p0 || ex_ready;
    assign load_en = advance && id_valid && !stall;
    // During a flush the offered instruction is consumed and dropped.
    assign id_ready = flush || (advance && !stall);

    // ---- ID -> EX register (p0) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0      <= 1'b0;
            pc_p0       <= '0;
            ctrl_p0     <= '0;
            rd_p0       <= '0;
            rs1_idx_p0  <= '0;
            rs2_idx_p0  <= '0;
            rs1_data_p0 <= '0;
            rs2_data_p0 <= '0;
            imm_p0      <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (advance) begin
            vld_p0 <= load_en;
            if (load_en) begin
                pc_p0       <= id_pc;
                ctrl_p0     <= id_ctrl_s;
                rd_p0       <= id_rd;
                rs1_idx_p0  <= id_rs1;
                rs2_idx_p0  <= id_rs2;
                rs1_data_p0 <= wb_snoop(id_rs1, id_rs1_data);
                rs2_data_p0 <= wb_snoop(id_rs2, id_rs2_data);
                imm_p0      <= id_imm;
            end
        end else begin
            // Holding under backpressure: keep absorbing retiring writes so the
            // operand is still correct once the WB forward path is gone.
            rs1_data_p0 <= wb_snoop(rs1_idx_p0, rs1_data_p0);
            rs2_data_p0 <= wb_snoop(rs2_idx_p0, rs2_data_p0);
        end
    end

    // ---- EX operand selection (combinational from p0 and MEM/WB) ----
    logic [DATA_W-1:0] rs1_fwd;
    logic [DATA_W-1:0] rs2_fwd;

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs1 (
        .idx         (rs1_idx_p0),
        .stored_data (rs1_data_p0),
        .mem_rd      (mem_rd),
        .mem_wen     (mem_wen),
        .mem_data    (mem_data),
        .wb_rd       (wb_rd),
        .wb_wen      (wb_wen),
        .wb_data     (wb_data),
        .fwd_data    (rs1_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs2 (
        .idx         (rs2_idx_p0),
        .stored_data (rs2_data_p0),
        .mem_rd      (mem_rd),
        .mem_wen     (mem_wen),
        .mem_data    (mem_data),
        .wb_rd       (wb_rd),
        .wb_wen      (wb_wen),
        .wb_data     (wb_data),
        .fwd_data    (rs2_fwd)
    );

    assign ex_valid      = vld_p0;
    assign ex_pc         = pc_p0;
    assign ex_ctrl       = ctrl_p0;
    assign ex_rd         = rd_p0;
    assign ex_a          = ctrl_p0.use_pc  ? pc_p0  : rs1_fwd;
    assign ex_b          = ctrl_p0.use_imm ? imm_p0 : rs2_fwd;
    assign ex_store_data = rs2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [14:0] id_ctrl;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic        flush;
    logic [4:0]  mem_rd;
    logic        mem_wen;
    logic [63:0] mem_data;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [63:0] wb_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic [14:0] ex_ctrl;
    logic [4:0]  ex_rd;
    logic [63:0] ex_a, ex_b, ex_store_data;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .flush(flush), .mem_rd(mem_rd), .mem_wen(mem_wen),
        .mem_data(mem_data), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the instruction currently sitting in EX, as a transaction
    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic [14:0] ctrl;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] d1, d2, imm;
    } ex_m_t;

    ex_m_t m;

    function automatic logic [63:0] wb_pick(input logic [4:0] idx, input logic [63:0] d);
        if (wb_wen && wb_rd == idx && idx != 0) return wb_data;
        return d;
    endfunction

    function automatic logic [63:0] fwd(input logic [4:0] idx, input logic [63:0] d);
        if (mem_wen && mem_rd == idx && idx != 0) return mem_data;
        return wb_pick(idx, d);
    endfunction

    function automatic logic m_stall();
        return m.v && m.ctrl[CTRL_MEM_READ] && m.rd != 0 &&
               ((id_ctrl[CTRL_RS1_USED] && id_rs1 == m.rd) ||
                (id_ctrl[CTRL_RS2_USED] && id_rs2 == m.rd));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m = '{default: '0};
        end else if (flush) begin
            m.v = 1'b0;
        end else if (!m.v || ex_ready) begin
            if (id_valid && !m_stall()) begin
                m.v    = 1'b1;
                m.pc   = id_pc;
                m.ctrl = id_ctrl;
                m.rd   = id_rd;
                m.rs1  = id_rs1;
                m.rs2  = id_rs2;
                m.d1   = wb_pick(id_rs1, id_rs1_data);
                m.d2   = wb_pick(id_rs2, id_rs2_data);
                m.imm  = id_imm;
            end else begin
                m.v = 1'b0;
            end
        end else begin
            m.d1 = wb_pick(m.rs1, m.d1);
            m.d2 = wb_pick(m.rs2, m.d2);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_ex_valid", ex_valid, m.v);
            if (!rst)
                chk("m_id_ready", id_ready, flush ? 1'b1 : ((!m.v || ex_ready) && !m_stall()));
            if (m.v) begin
                chk("m_ex_pc", ex_pc, m.pc);
                chk("m_ex_ctrl", ex_ctrl, m.ctrl);
                chk("m_ex_rd", ex_rd, m.rd);
                chk("m_ex_a", ex_a, m.ctrl[CTRL_USE_PC] ? m.pc : fwd(m.rs1, m.d1));
                chk("m_ex_b", ex_b, m.ctrl[CTRL_USE_IMM] ? m.imm : fwd(m.rs2, m.d2));
                chk("m_ex_store", ex_store_data, fwd(m.rs2, m.d2));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        id_valid = 0; flush = 0; mem_wen = 0; wb_wen = 0;
        mem_rd = 0; wb_rd = 0; mem_data = 0; wb_data = 0;
    endtask

    task automatic offer(input logic [63:0] pc, input logic [14:0] c,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm);
        id_valid = 1; id_pc = pc; id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    endtask

    logic [14:0] c;

    initial begin
        rst = 1; ex_ready = 1;
        quiet();
        offer(0, 0, 0, 0, 0, 0, 0, 0);
        id_valid = 0;

        // Reset
        step();
        rst = 0;
        cmp_on = 1;
        #2;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_a", ex_a, 0);
        chk("rst_ex_b", ex_b, 0);
        chk("rst_ex_store", ex_store_data, 0);
        chk("rst_id_ready", id_ready, 1);

        // Forwarding priority on a held rs1=x5
        ex_ready = 0;
        c = '0; c[CTRL_RS1_USED] = 1;
        offer(64'h100, c, 5, 0, 3, 64'h10, 0, 0);
        step();
        id_valid = 0;
        mem_rd = 5; mem_wen = 1; mem_data = 64'h20;
        wb_rd = 5; wb_wen = 1; wb_data = 64'h30;
        #2;
        chk("fwd_mem_over_wb", ex_a, 64'h20);
        mem_wen = 0;
        #1;
        chk("fwd_wb", ex_a, 64'h30);
        ex_ready = 1;
        offer(64'h104, c, 0, 0, 3, 0, 0, 0);
        mem_rd = 0; mem_wen = 1; mem_data = 64'h20;
        wb_rd = 0; wb_wen = 1; wb_data = 64'h30;
        step();
        id_valid = 0;
        #2;
        chk("fwd_x0_valid", ex_valid, 1);
        chk("fwd_x0", ex_a, 0);

        // Load-use: one bubble
        quiet();
        c = '0; c[CTRL_MEM_READ] = 1; c[CTRL_RD_WEN] = 1;
        offer(64'h1F0, c, 1, 0, 7, 0, 0, 0);
        step();
        c = '0; c[CTRL_RS2_USED] = 1;
        offer(64'h200, c, 0, 7, 8, 0, 64'h77, 0);
        #2;
        chk("lu_id_ready_low", id_ready, 0);
        chk("lu_load_in_ex", ex_pc, 64'h1F0);
        step();
        #2;
        chk("lu_bubble", ex_valid, 0);
        chk("lu_id_ready_back", id_ready, 1);
        step();
        id_valid = 0;
        #2;
        chk("lu_dep_valid", ex_valid, 1);
        chk("lu_dep_pc", ex_pc, 64'h200);
        chk("lu_dep_rd", ex_rd, 8);

        // Backpressure with a write retiring mid-hold
        c = '0; c[CTRL_RS1_USED] = 1; c[CTRL_ALU_OP_LSB +: 4] = 4'd3;
        offer(64'h300, c, 9, 0, 10, 64'h1111, 0, 0);
        step();
        id_valid = 0; ex_ready = 0;
        step();
        wb_rd = 9; wb_wen = 1; wb_data = 64'hDEAD;
        step();
        wb_wen = 0;
        #2;
        chk("bp_ex_a", ex_a, 64'hDEAD);
        chk("bp_ex_pc", ex_pc, 64'h300);
        chk("bp_ex_ctrl", ex_ctrl, {49'd0, c});
        chk("bp_valid", ex_valid, 1);

        // Flush while stalled downstream
        offer(64'h400, 15'h0, 1, 2, 3, 0, 0, 0);
        flush = 1;
        #1;
        chk("fl_id_ready", id_ready, 1);
        step();
        flush = 0; id_valid = 0; ex_ready = 1;
        #2;
        chk("fl_bubble", ex_valid, 0);
        step();
        #2;
        chk("fl_never_appears", ex_valid, 0);

        // Operand select
        c = '0; c[CTRL_USE_PC] = 1; c[CTRL_USE_IMM] = 1;
        offer(64'h80000000, c, 1, 2, 4, 64'h5, 64'h6, 64'hFFFFFFFFFFFFFFFC);
        step();
        id_valid = 0;
        #2;
        chk("os_ex_a", ex_a, 64'h80000000);
        chk("os_ex_b", ex_b, 64'hFFFFFFFFFFFFFFFC);
        chk("os_store", ex_store_data, 64'h6);

        // Reset concurrent with flush and an offer
        offer(64'h500, 15'h0, 1, 2, 3, 1, 2, 3);
        flush = 1; rst = 1;
        step();
        rst = 0; flush = 0; id_valid = 0;
        #2;
        chk("rst2_valid", ex_valid, 0);
        chk("rst2_pc", ex_pc, 0);
        chk("rst2_a", ex_a, 0);

        // Randomized traffic, small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            step();
            rst         = ($urandom_range(0, 63) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            ex_ready    = ($urandom_range(0, 3) != 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_pc       = {$urandom, $urandom};
            id_ctrl     = 15'($urandom);
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rd       = 5'($urandom_range(0, 7));
            id_rs1_data = {$urandom, $urandom};
            id_rs2_data = {$urandom, $urandom};
            id_imm      = {$urandom, $urandom};
            mem_rd      = 5'($urandom_range(0, 7));
            mem_wen     = $urandom_range(0, 1);
            mem_data    = {$urandom, $urandom};
            wb_rd       = 5'($urandom_range(0, 7));
            wb_wen      = $urandom_range(0, 1);
            wb_data     = {$urandom, $urandom};
        end

        step();
        rst = 0;
        quiet();
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
